// File: rtl/d19012_uart_rx.sv
// d19012_uart_rx: receive PHY for one command UART line.
// Frame: start, 8 data bits LSB first, optional parity bit, one stop bit.
// Each bit is decided by a 3-sample majority vote around mid-bit. The
// stop bit is acted on at its mid-sample, which leaves half a bit of slack
// so that back-to-back frames can resynchronise on the next start edge.
module d19012_uart_rx #(
    parameter int U_DLY      = 1,
    parameter int CLK_FREQ   = 60000000,
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       rx_par_err,
    output logic       rx_frm_err,
    output logic       rx_brk,
    output logic       rx_busy
);

    // U_DLY only matters to simulation models that add register delays; this
    // RTL models none, so the parameter is kept for instantiation compatibility.
    if (U_DLY < 0) begin : g_u_dly_unused
    end

    localparam int          BIT_DIV_I = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] BIT_DIV   = 16'(BIT_DIV_I);
    localparam logic [15:0] BIT_LAST  = BIT_DIV - 16'd1;
    localparam logic [15:0] SMP_A     = (BIT_DIV >> 1) - 16'd1;
    localparam logic [15:0] SMP_B     = (BIT_DIV >> 1);
    localparam logic [15:0] SMP_C     = (BIT_DIV >> 1) + 16'd1;
    // Break threshold: two full 11-bit frame times of continuous low.
    localparam logic [23:0] BRK_LAST  = 24'(22 * BIT_DIV_I - 1);
    localparam logic        PAR_EN_B  = (PARITY_EN != 0);
    localparam logic        PAR_ODD_B = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } state_t;

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        maj3 = (a & b) | (a & c) | (b & c);
    endfunction

    // High when the received parity bit disagrees with the data byte.
    function automatic logic par_mismatch(input logic [7:0] d, input logic p, input logic odd);
        par_mismatch = (^d) ^ p ^ odd;
    endfunction

    logic        sync1_r, sync2_r, prev_r;
    logic        start_s, line_s, vote_s, mid_s;
    state_t      state_r, state_nxt_s;
    logic [15:0] cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [2:0]  bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0]  shift_r, shift_nxt_s;
    logic [1:0]  smp_r, smp_nxt_s;
    logic        par_bad_r, par_bad_nxt_s;
    logic [23:0] low_cnt_r, low_cnt_nxt_s;
    logic [7:0]  rx_data_r, data_nxt_s;
    logic        rx_vld_r, vld_nxt_s;
    logic        rx_par_err_r, par_err_nxt_s;
    logic        rx_frm_err_r, frm_nxt_s;
    logic        rx_brk_r, brk_nxt_s;
    logic        rx_busy_r, busy_nxt_s;

    assign line_s    = sync2_r;
    assign start_s   = prev_r & ~sync2_r;
    assign vote_s    = maj3(smp_r[1], smp_r[0], line_s);
    assign mid_s     = (cnt_r == SMP_C);
    assign cnt_inc_s = (cnt_r == BIT_LAST) ? 16'd0 : (cnt_r + 16'd1);

    // Two-flop synchroniser plus edge-detect flop, preset high (idle line).
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= uart_rx;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Next-state, datapath and output-pulse decode for the receive FSM.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        smp_nxt_s     = smp_r;
        par_bad_nxt_s = par_bad_r;
        data_nxt_s    = rx_data_r;
        vld_nxt_s     = 1'b0;
        par_err_nxt_s = 1'b0;
        frm_nxt_s     = 1'b0;

        if (cnt_r == SMP_A) begin
            smp_nxt_s[1] = line_s;
        end else if (cnt_r == SMP_B) begin
            smp_nxt_s[0] = line_s;
        end else begin
            smp_nxt_s = smp_r;
        end

        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s     = 16'd0;
                bit_cnt_nxt_s = 3'd0;
                if (start_s) begin
                    state_nxt_s   = ST_START;
                    par_bad_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_nxt_s = cnt_inc_s;
                if (mid_s) begin
                    if (vote_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                cnt_nxt_s = cnt_inc_s;
                if (mid_s) begin
                    shift_nxt_s = {vote_s, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        bit_cnt_nxt_s = 3'd0;
                        state_nxt_s   = PAR_EN_B ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                cnt_nxt_s = cnt_inc_s;
                if (mid_s) begin
                    par_bad_nxt_s = par_mismatch(shift_r, vote_s, PAR_ODD_B);
                    state_nxt_s   = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                cnt_nxt_s = cnt_inc_s;
                if (mid_s) begin
                    if (vote_s) begin
                        vld_nxt_s     = 1'b1;
                        data_nxt_s    = shift_r;
                        par_err_nxt_s = par_bad_r;
                        state_nxt_s   = ST_IDLE;
                    end else begin
                        frm_nxt_s   = 1'b1;
                        cnt_nxt_s   = 16'd0;
                        state_nxt_s = ST_BRK_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_BRK_WAIT: begin
                // Counter measures consecutive high clocks here.
                if (line_s) begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_nxt_s   = 16'd0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r + 16'd1;
                    end
                end else begin
                    cnt_nxt_s = 16'd0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 16'd0;
            end
        endcase
    end

    // Continuous-low run length; the break fires once as the run reaches threshold.
    always_comb begin
        low_cnt_nxt_s = low_cnt_r;
        if (line_s) begin
            low_cnt_nxt_s = 24'd0;
        end else if (low_cnt_r <= BRK_LAST) begin
            low_cnt_nxt_s = low_cnt_r + 24'd1;
        end else begin
            low_cnt_nxt_s = low_cnt_r;
        end
        brk_nxt_s  = (state_r != ST_IDLE) && !line_s && (low_cnt_r == BRK_LAST);
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 16'd0;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            smp_r        <= 2'b11;
            par_bad_r    <= 1'b0;
            low_cnt_r    <= 24'd0;
            rx_data_r    <= 8'h00;
            rx_vld_r     <= 1'b0;
            rx_par_err_r <= 1'b0;
            rx_frm_err_r <= 1'b0;
            rx_brk_r     <= 1'b0;
            rx_busy_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            shift_r      <= shift_nxt_s;
            smp_r        <= smp_nxt_s;
            par_bad_r    <= par_bad_nxt_s;
            low_cnt_r    <= low_cnt_nxt_s;
            rx_data_r    <= data_nxt_s;
            rx_vld_r     <= vld_nxt_s;
            rx_par_err_r <= par_err_nxt_s;
            rx_frm_err_r <= frm_nxt_s;
            rx_brk_r     <= brk_nxt_s;
            rx_busy_r    <= busy_nxt_s;
        end
    end

    assign rx_data    = rx_data_r;
    assign rx_vld     = rx_vld_r;
    assign rx_par_err = rx_par_err_r;
    assign rx_frm_err = rx_frm_err_r;
    assign rx_brk     = rx_brk_r;
    assign rx_busy    = rx_busy_r;

endmodule

// File: tb/tb_d19012_uart_rx.sv
// Directed bench for d19012_uart_rx at 60 MHz / 115200 baud (520 clocks per bit).
`timescale 1ns/1ps
module tb_d19012_uart_rx;

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_vld, rx_par_err, rx_frm_err, rx_brk, rx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Output event log filled by the monitor.
    logic [7:0] q_data[$];
    logic       q_par[$];
    int         last_vld_cyc = 0;
    int         frm_cnt = 0, brk_cnt = 0, excl_cnt = 0, orphan_cnt = 0;

    d19012_uart_rx dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_vld     (rx_vld),
        .rx_par_err (rx_par_err),
        .rx_frm_err (rx_frm_err),
        .rx_brk     (rx_brk),
        .rx_busy    (rx_busy)
    );

    always #8.333 clk_sys = ~clk_sys;

    // Free-running cycle count.
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Record output pulses on the falling edge, away from the active edge.
    always @(negedge clk_sys) begin
        if (rx_vld) begin
            q_data.push_back(rx_data);
            q_par.push_back(rx_par_err);
            last_vld_cyc <= cyc;
        end
        if (rx_frm_err)            frm_cnt    <= frm_cnt + 1;
        if (rx_brk)                brk_cnt    <= brk_cnt + 1;
        if (rx_vld && rx_frm_err)  excl_cnt   <= excl_cnt + 1;
        if (rx_par_err && !rx_vld) orphan_cnt <= orphan_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame bits LSB first: start, D0..D7, parity (even, optionally flipped), stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic pflip, input logic stop);
        mk_frame = {stop, (^d) ^ pflip, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int bitcyc);
        for (int i = 0; i < nbits; i++) begin
            uart_rx = bits[i];
            repeat (bitcyc) @(negedge clk_sys);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic pflip, input logic stop, input int bitcyc);
        send_bits(mk_frame(d, pflip, stop), 11, bitcyc);
    endtask

    int            base, frm0, brk0, fall_cyc, lat;
    logic [7:0]    seq [6];
    logic [10:0]   fr;

    initial begin
        seq[0] = 8'hEF; seq[1] = 8'h91; seq[2] = 8'h19;
        seq[3] = 8'hFE; seq[4] = 8'h00; seq[5] = 8'h10;

        // Reset state
        repeat (10) @(negedge clk_sys);
        chk("rst_data", {24'd0, rx_data}, 32'h00);
        chk("rst_vld",  {31'd0, rx_vld}, 32'd0);
        chk("rst_par",  {31'd0, rx_par_err}, 32'd0);
        chk("rst_frm",  {31'd0, rx_frm_err}, 32'd0);
        chk("rst_brk",  {31'd0, rx_brk}, 32'd0);
        chk("rst_busy", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        chk("no_false_start", {31'd0, rx_busy}, 32'd0);

        // 0x91, correct even parity (bit = 1), latency from falling edge
        base = q_data.size();
        fall_cyc = cyc;
        send_byte(8'h91, 1'b0, 1'b1, 520);
        repeat (100) @(negedge clk_sys);
        chk("t1_count", q_data.size() - base, 32'd1);
        if (q_data.size() > base) begin
            chk("t1_data", {24'd0, q_data[base]}, 32'h91);
            chk("t1_par",  {31'd0, q_par[base]}, 32'd0);
        end
        lat = last_vld_cyc - fall_cyc;
        chk("t1_latency_5464pm2", {31'd0, (lat >= 5462) && (lat <= 5466)}, 32'd1);

        // 0xEF with the parity bit inverted
        base = q_data.size();
        send_byte(8'hEF, 1'b1, 1'b1, 520);
        repeat (100) @(negedge clk_sys);
        chk("t2_count", q_data.size() - base, 32'd1);
        if (q_data.size() > base) begin
            chk("t2_data", {24'd0, q_data[base]}, 32'hEF);
            chk("t2_par",  {31'd0, q_par[base]}, 32'd1);
        end

        // Back-to-back stream, no idle gap
        base = q_data.size();
        frm0 = frm_cnt;
        for (int i = 0; i < 6; i++) send_byte(seq[i], 1'b0, 1'b1, 520);
        repeat (100) @(negedge clk_sys);
        chk("t3_count", q_data.size() - base, 32'd6);
        if (q_data.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("t3_data%0d", i), {24'd0, q_data[base + i]}, {24'd0, seq[i]});
                chk($sformatf("t3_par%0d", i),  {31'd0, q_par[base + i]}, 32'd0);
            end
        end
        chk("t3_frm", frm_cnt - frm0, 32'd0);

        // 0x55 with stop low, then long low (break), then 0xA5.
        // 0x55 is already low from D7 on; 12000 more low clocks exceed 22 bit times.
        base = q_data.size();
        frm0 = frm_cnt;
        brk0 = brk_cnt;
        send_byte(8'h55, 1'b0, 1'b0, 520);
        chk("t4_frm", frm_cnt - frm0, 32'd1);
        chk("t4_no_vld", q_data.size() - base, 32'd0);
        chk("t4_data_held", {24'd0, rx_data}, 32'h10);
        repeat (12000) @(negedge clk_sys);
        chk("t4_brk", brk_cnt - brk0, 32'd1);
        uart_rx = 1'b1;
        repeat (1100) @(negedge clk_sys);
        send_byte(8'hA5, 1'b0, 1'b1, 520);
        repeat (100) @(negedge clk_sys);
        chk("t4_brk_once", brk_cnt - brk0, 32'd1);
        chk("t4_count", q_data.size() - base, 32'd1);
        if (q_data.size() > base) chk("t4_data", {24'd0, q_data[base]}, 32'hA5);

        // Glitch on idle line, then 0x3C at +2.5% and -2.5% baud
        base = q_data.size();
        frm0 = frm_cnt;
        uart_rx = 1'b0;
        repeat (6) @(negedge clk_sys);
        uart_rx = 1'b1;
        repeat (1200) @(negedge clk_sys);
        chk("t5_glitch_none", q_data.size() - base, 32'd0);
        chk("t5_glitch_busy", {31'd0, rx_busy}, 32'd0);
        send_byte(8'h3C, 1'b0, 1'b1, 507);
        repeat (520) @(negedge clk_sys);
        send_byte(8'h3C, 1'b0, 1'b1, 533);
        repeat (100) @(negedge clk_sys);
        chk("t5_count", q_data.size() - base, 32'd2);
        if (q_data.size() >= base + 2) begin
            chk("t5_fast_data", {24'd0, q_data[base]}, 32'h3C);
            chk("t5_fast_par",  {31'd0, q_par[base]}, 32'd0);
            chk("t5_slow_data", {24'd0, q_data[base + 1]}, 32'h3C);
            chk("t5_slow_par",  {31'd0, q_par[base + 1]}, 32'd0);
        end
        chk("t5_frm", frm_cnt - frm0, 32'd0);

        // Reset in the middle of data bit 4 of 0x81, then 0x7E
        fr = mk_frame(8'h81, 1'b0, 1'b1);
        send_bits(fr, 5, 520);
        uart_rx = fr[5];
        repeat (260) @(negedge clk_sys);
        chk("t6_busy_mid", {31'd0, rx_busy}, 32'd1);
        rst_n = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk_sys);
        chk("t6_rst_busy", {31'd0, rx_busy}, 32'd0);
        chk("t6_rst_data", {24'd0, rx_data}, 32'h00);
        base = q_data.size();
        frm0 = frm_cnt;
        rst_n = 1'b1;
        repeat (2000) @(negedge clk_sys);
        chk("t6_no_output", q_data.size() - base, 32'd0);
        chk("t6_no_frm", frm_cnt - frm0, 32'd0);
        send_byte(8'h7E, 1'b0, 1'b1, 520);
        repeat (100) @(negedge clk_sys);
        chk("t6_count", q_data.size() - base, 32'd1);
        if (q_data.size() > base) chk("t6_data", {24'd0, q_data[base]}, 32'h7E);

        // Cross-cutting pulse rules over the whole run
        chk("vld_frm_exclusive", excl_cnt, 32'd0);
        chk("par_err_only_with_vld", orphan_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
